// File: rtl/move_receiver_if.sv
// -----------------------------------------------------------------------------
// move_receiver_if
// Opponent-move handshake between the game controller (master) and the move
// receiver (slave).
//
// Parameter:
//   CELLS         number of board cells (ROWS*COLS of the receiver)
// Signals:
//   recv_req      master -> slave  one-cycle request for a user move
//   recv_ready    slave  -> master receiver idle / result valid
//   recv_error    slave  -> master last move invalid (valid while ready=1)
//   recv_board_a  slave  -> master board A after the user move
//   recv_board_b  slave  -> master board B after the user move
// -----------------------------------------------------------------------------
interface move_receiver_if #(
  parameter int CELLS = 9
);
  logic             recv_req;
  logic             recv_ready;
  logic             recv_error;
  logic [CELLS-1:0] recv_board_a;
  logic [CELLS-1:0] recv_board_b;

  modport master (
    output recv_req,
    input  recv_ready,
    input  recv_error,
    input  recv_board_a,
    input  recv_board_b
  );

  modport slave (
    input  recv_req,
    output recv_ready,
    output recv_error,
    output recv_board_a,
    output recv_board_b
  );
endinterface

// File: rtl/move_receiver.sv
// -----------------------------------------------------------------------------
// move_receiver
// Responder side of the opponent-move handshake. After an accepted request it
// parses one user move from the UART RX byte stream (a single cell digit
// '1'..'9' followed by CR or LF, spaces ignored), validates it against the
// boards latched at request time and returns the updated boards or an error.
//
// Optional feature (macro MOVE_RECEIVER_TIMEOUT_EN): an idle-byte timeout of
// TIMEOUT_CYCLES clocks while parsing; on expiry the move is reported as an
// error with the latched boards. Without the macro the block waits forever.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   rif          handshake (slave): recv_req in; recv_ready, recv_error,
//                recv_board_a, recv_board_b out
//   my_target_a  1: FPGA plays A, user plays B; 0: user plays A
//   board_a      current A board, sampled on accepted request
//   board_b      current B board, sampled on accepted request
//   rx_valid     one-cycle strobe, RX byte available
//   rx_data      RX byte
// -----------------------------------------------------------------------------
module move_receiver #(
  parameter int          ROWS           = 3,
  parameter int          COLS           = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  move_receiver_if.slave       rif,
  input  logic                 my_target_a,
  input  logic [ROWS*COLS-1:0] board_a,
  input  logic [ROWS*COLS-1:0] board_b,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data
);

  localparam int CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DIGIT,
    WAIT_TERM,
    DRAIN,
    CHECK
  } state_t;

  state_t           state;
  logic             accept;
  logic             is_digit;
  logic             is_term;
  logic             is_space;
  logic             cell_bad;
  logic             tmo_hit;
  logic [3:0]       idx;
  logic             lat_tgt;
  logic [CELLS-1:0] lat_a;
  logic [CELLS-1:0] lat_b;
  logic [CELLS-1:0] sel;
  logic             recv_error;
  logic [CELLS-1:0] recv_board_a;
  logic [CELLS-1:0] recv_board_b;

  assign accept   = (state == IDLE) && rif.recv_req;
  assign is_digit = (rx_data >= 8'h31) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_space = (rx_data == 8'h20);

  // One-hot cell select; an index past the last cell shifts the bit out, so an
  // all-zero select doubles as the out-of-range flag.
  assign sel      = CELLS'(1) << idx;
  assign cell_bad = (sel == '0) || (|((lat_a | lat_b) & sel));

  // Combinational so ready drops in the very cycle the request is raised.
  assign rif.recv_ready   = (state == IDLE) && !rif.recv_req;
  assign rif.recv_error   = recv_error;
  assign rif.recv_board_a = recv_board_a;
  assign rif.recv_board_b = recv_board_b;

`ifdef MOVE_RECEIVER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        parsing;

  assign parsing = (state == WAIT_DIGIT) || (state == WAIT_TERM) || (state == DRAIN);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign tmo_hit = parsing && !rx_valid && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (accept || rx_valid) begin
      tmo_cnt <= '0;
    end else if (parsing) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Request snapshot and parsed cell index (data path, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_a   <= board_a;
      lat_b   <= board_b;
      lat_tgt <= my_target_a;
    end
    if ((state == WAIT_DIGIT) && rx_valid && is_digit) begin
      idx <= rx_data[3:0] - 4'd1;
    end
  end

  // Parser / checker FSM with registered results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      recv_error   <= 1'b0;
      recv_board_a <= '0;
      recv_board_b <= '0;
    end else if (tmo_hit) begin
      recv_error   <= 1'b1;
      recv_board_a <= lat_a;
      recv_board_b <= lat_b;
      state        <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Bytes here, including one coincident with the request, are dropped.
          if (rif.recv_req) begin
            recv_error <= 1'b0;
            state      <= WAIT_DIGIT;
          end
        end
        WAIT_DIGIT: begin
          if (rx_valid) begin
            if (is_digit) begin
              state <= WAIT_TERM;
            end else if (!(is_term || is_space)) begin
              state <= DRAIN;
            end
          end
        end
        WAIT_TERM: begin
          if (rx_valid) begin
            if (is_term) begin
              state <= CHECK;
            end else if (!is_space) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Swallow the rest of a malformed line before reporting it.
          if (rx_valid && is_term) begin
            recv_error   <= 1'b1;
            recv_board_a <= lat_a;
            recv_board_b <= lat_b;
            state        <= IDLE;
          end
        end
        CHECK: begin
          recv_board_a <= lat_a;
          recv_board_b <= lat_b;
          if (cell_bad) begin
            recv_error <= 1'b1;
          end else begin
            recv_error <= 1'b0;
            if (lat_tgt) begin
              recv_board_b <= lat_b | sel;
            end else begin
              recv_board_a <= lat_a | sel;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_receiver.sv
// -----------------------------------------------------------------------------
// tb_move_receiver
// Directed bench for move_receiver: a 3x3 instance for the main move cases and
// a 2x2 instance for the out-of-range index. Both share the RX byte lines; an
// idle receiver ignores bytes. The timeout cases are compiled only with
// MOVE_RECEIVER_TIMEOUT_EN (instances use TIMEOUT_CYCLES=16).
// -----------------------------------------------------------------------------
module tb_move_receiver;

  logic       clk;
  logic       reset_n;
  logic       my_target_a;
  logic [8:0] board_a;
  logic [8:0] board_b;
  logic       rx_valid;
  logic [7:0] rx_data;

  int n_vec;
  int n_miscmp;

  move_receiver_if #(.CELLS(9)) rif ();
  move_receiver_if #(.CELLS(4)) rif2 ();

  move_receiver #(.ROWS(3), .COLS(3), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rif         (rif.slave),
    .my_target_a (my_target_a),
    .board_a     (board_a),
    .board_b     (board_b),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data)
  );

  move_receiver #(.ROWS(2), .COLS(2), .TIMEOUT_CYCLES(32'd16)) dut2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .rif         (rif2.slave),
    .my_target_a (my_target_a),
    .board_a     (board_a[3:0]),
    .board_b     (board_b[3:0]),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Request on the 3x3 instance; optionally with a coincident RX byte '3'.
  task automatic req1(input logic [8:0] a, input logic [8:0] b, input logic tgt,
                      input logic with_byte);
    chk("rdy_idle", rif.recv_ready, 1);
    board_a     = a;
    board_b     = b;
    my_target_a = tgt;
    rif.recv_req = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'h33;
    end
    #1;
    chk("rdy_drop_on_req", rif.recv_ready, 0);
    tick(1);
    rif.recv_req = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic req2(input logic [3:0] a, input logic [3:0] b, input logic tgt);
    chk("rdy2_idle", rif2.recv_ready, 1);
    board_a       = {5'd0, a};
    board_b       = {5'd0, b};
    my_target_a   = tgt;
    rif2.recv_req = 1'b1;
    tick(1);
    rif2.recv_req = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_miscmp      = 0;
    reset_n       = 1'b0;
    my_target_a   = 1'b0;
    board_a       = '0;
    board_b       = '0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    rif.recv_req  = 1'b0;
    rif2.recv_req = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_ready", rif.recv_ready, 1);
    chk("rst_error", rif.recv_error, 0);
    chk("rst_board_a", rif.recv_board_a, 0);
    chk("rst_board_b", rif.recv_board_b, 0);
    chk("rst2_ready", rif2.recv_ready, 1);

    // Empty boards, user plays B, cell 5 -> bit 4 of B
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    send_str("5\r");
    chk("t1_busy_in_check", rif.recv_ready, 0);
    tick(1);
    chk("t1_ready", rif.recv_ready, 1);
    chk("t1_error", rif.recv_error, 0);
    chk("t1_board_a", rif.recv_board_a, 9'h000);
    chk("t1_board_b", rif.recv_board_b, 9'h010);

    // Occupied cell on A, user plays A
    req1(9'h010, 9'h000, 1'b0, 1'b0);
    send_str("5\n");
    tick(1);
    chk("t2_error", rif.recv_error, 1);
    chk("t2_board_a", rif.recv_board_a, 9'h010);
    chk("t2_board_b", rif.recv_board_b, 9'h000);

    // 2x2 board: cell 7 is out of range, cell 4 is the last valid cell
    req2(4'h0, 4'h0, 1'b0);
    send_str("7\r");
    tick(1);
    chk("t3_ready", rif2.recv_ready, 1);
    chk("t3_error", rif2.recv_error, 1);
    req2(4'h0, 4'h0, 1'b0);
    send_str("4\r");
    tick(1);
    chk("t3b_error", rif2.recv_error, 0);
    chk("t3b_board_a", rif2.recv_board_a, 4'h8);

    // Garbage first byte drains the line; error only after the terminator
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    send_str("x3");
    chk("t4_drain_busy", rif.recv_ready, 0);
    chk("t4_drain_noerr", rif.recv_error, 0);
    send_str("\r");
    chk("t4_ready", rif.recv_ready, 1);
    chk("t4_error", rif.recv_error, 1);

    // Spaces around the digit, LF terminator, user plays A, cell 1
    req1(9'h100, 9'h002, 1'b0, 1'b0);
    send_str(" 1 \n");
    tick(1);
    chk("t5_error", rif.recv_error, 0);
    chk("t5_board_a", rif.recv_board_a, 9'h101);
    chk("t5_board_b", rif.recv_board_b, 9'h002);

    // Two digits is malformed
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    send_str("12\r");
    chk("t6_ready", rif.recv_ready, 1);
    chk("t6_error", rif.recv_error, 1);

    // '0' is not a valid cell digit
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    send_str("0\r");
    chk("t7_error", rif.recv_error, 1);

    // Request while busy is ignored; the first snapshot is used
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    board_a      = 9'h1FF;
    board_b      = 9'h1FF;
    rif.recv_req = 1'b1;
    #1;
    chk("t8_busy_req_rdy", rif.recv_ready, 0);
    tick(1);
    rif.recv_req = 1'b0;
    send_str("9\r");
    tick(1);
    chk("t8_error", rif.recv_error, 0);
    chk("t8_board_a", rif.recv_board_a, 9'h000);
    chk("t8_board_b", rif.recv_board_b, 9'h100);

    // Byte coincident with the accepted request is dropped
    req1(9'h001, 9'h000, 1'b1, 1'b1);
    send_str("2\r");
    tick(1);
    chk("t9_error", rif.recv_error, 0);
    chk("t9_board_a", rif.recv_board_a, 9'h001);
    chk("t9_board_b", rif.recv_board_b, 9'h002);

    // Asynchronous reset mid-parse
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    send_str("4");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t10_rst_ready", rif.recv_ready, 1);
    chk("t10_rst_board_a", rif.recv_board_a, 0);
    chk("t10_rst_board_b", rif.recv_board_b, 0);
    tick(1);
    reset_n = 1'b1;
    send_str("\r");
    tick(2);
    chk("t10_no_done_ready", rif.recv_ready, 1);
    chk("t10_no_done_error", rif.recv_error, 0);
    chk("t10_no_done_board_b", rif.recv_board_b, 0);

`ifdef MOVE_RECEIVER_TIMEOUT_EN
    // No bytes: error after 16 parsing cycles
    req1(9'h004, 9'h000, 1'b1, 1'b0);
    tick(15);
    chk("tmo_pre", rif.recv_ready, 0);
    tick(1);
    chk("tmo_ready", rif.recv_ready, 1);
    chk("tmo_error", rif.recv_error, 1);
    chk("tmo_board_a", rif.recv_board_a, 9'h004);

    // A byte every 10 cycles keeps the counter from expiring
    req1(9'h000, 9'h000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(9);
      send_byte(8'h20);
    end
    chk("tmo_alive", rif.recv_ready, 0);
    send_str("1\r");
    tick(1);
    chk("tmo_alive_error", rif.recv_error, 0);
    chk("tmo_alive_board_b", rif.recv_board_b, 9'h001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
